// File: rtl/lc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lc_pkg
// Description : Shared definitions for the little-computer control path.
//               It holds the opcode constants, the sequencer state encoding,
//               the instruction classes and the opcode classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package lc_pkg;

    // 4-bit opcode patterns. These are matched against the top four bits of
    // the opcode field.
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1001;
    localparam logic [3:0] OP_JUMP  = 4'b1010;
    localparam logic [3:0] OP_LOAD  = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Sequencer states. The encoding is explicit so that it stays stable.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_STORE = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_BEQ   = 3'd3,
        CLS_JUMP  = 3'd4,
        CLS_HALT  = 3'd5,
        CLS_NOP   = 3'd6
    } instr_class_t;

    // Opcodes 00xx and 01xx are ALU operations. Any 1xxx opcode without a
    // dedicated meaning is treated as a NOP.
    function automatic instr_class_t classify(input logic [3:0] op4);
        instr_class_t cls;
        cls = CLS_NOP;
        if (!op4[3]) begin
            cls = CLS_ALU;
        end else begin
            case (op4)
                OP_STORE: cls = CLS_STORE;
                OP_BEQ:   cls = CLS_BEQ;
                OP_JUMP:  cls = CLS_JUMP;
                OP_LOAD:  cls = CLS_LOAD;
                OP_HALT:  cls = CLS_HALT;
                default:  cls = CLS_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_decode.sv
`default_nettype none
// ============================================================================
// Module      : op_decode
// Description : Combinational opcode decoder. It maps an opcode to its
//               instruction class, the immediate-operand select and the ALU
//               operation field.
// Ports       : op       - opcode field (OP_WIDTH bits)
//               op_class - decoded instruction class
//               itype    - I-type ALU instruction (01xx)
//               alu_op   - ALU operation field
// Revision    : 1.0 - initial release
// ============================================================================
module op_decode
    import lc_pkg::*;
#(
    parameter int OP_WIDTH     = 4,
    parameter int ALU_OP_WIDTH = 2
) (
    input  logic [OP_WIDTH-1:0]     op,
    output instr_class_t            op_class,
    output logic                    itype,
    output logic [ALU_OP_WIDTH-1:0] alu_op
);

    assign op_class = classify(op[OP_WIDTH-1 -: 4]);
    assign itype    = ~op[OP_WIDTH-1] & op[OP_WIDTH-2];
    assign alu_op   = op[OP_WIDTH-3 -: ALU_OP_WIDTH];

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle control sequencer. The state sequence is
//               FETCH / DECODE / EXEC / MEM / WB / HALT. It drives the
//               datapath enables and a req/ack memory handshake, and it
//               keeps a retired-instruction counter.
// Ports       : clk, rst_n        - clock and asynchronous active-low reset
//               instr             - instruction register contents
//               alu_zero          - ALU zero flag, used by BEQ in EXEC
//               mem_ack           - memory has completed the current request
//               resume            - pulse that leaves HALT
//               mem_req/mem_we/mem_is_fetch - memory request signals
//               ir_en, pc_en, pc_src        - IR and PC update controls
//               reg_write_en, wb_from_mem   - register writeback controls
//               itype, alu_op               - ALU controls, meaningful in EXEC
//               halted, instret             - status outputs
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import lc_pkg::*;
#(
    parameter int INSTR_WIDTH  = 16,
    parameter int OP_WIDTH     = 4,
    parameter int ALU_OP_WIDTH = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INSTR_WIDTH-1:0]  instr,
    input  logic                    alu_zero,
    input  logic                    mem_ack,
    input  logic                    resume,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    mem_is_fetch,
    output logic                    ir_en,
    output logic                    pc_en,
    output logic                    pc_src,
    output logic                    reg_write_en,
    output logic                    wb_from_mem,
    output logic                    itype,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    halted,
    output logic [CNT_WIDTH-1:0]    instret
);

    ctrl_state_t             r_state;
    ctrl_state_t             w_next_state;
    logic [CNT_WIDTH-1:0]    r_instret;

    instr_class_t            w_class;
    logic                    w_itype;
    logic [ALU_OP_WIDTH-1:0] w_alu_op;
    logic                    w_retire;

    logic w_mem_req, w_mem_we, w_mem_is_fetch, w_ir_en, w_pc_en, w_pc_src;
    logic w_reg_write_en, w_wb_from_mem, w_halted;

    // Operand bits are not used by the control path.
    logic w_unused_operand;
    assign w_unused_operand = ^instr[INSTR_WIDTH-OP_WIDTH-1:0];

    op_decode #(
        .OP_WIDTH     (OP_WIDTH),
        .ALU_OP_WIDTH (ALU_OP_WIDTH)
    ) u_op_decode (
        .op       (instr[INSTR_WIDTH-1 -: OP_WIDTH]),
        .op_class (w_class),
        .itype    (w_itype),
        .alu_op   (w_alu_op)
    );

    always_comb begin
        w_next_state   = r_state;
        w_retire       = 1'b0;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_is_fetch = 1'b0;
        w_ir_en        = 1'b0;
        w_pc_en        = 1'b0;
        w_pc_src       = 1'b0;
        w_reg_write_en = 1'b0;
        w_wb_from_mem  = 1'b0;
        w_halted       = 1'b0;

        case (r_state)
            FETCH: begin
                w_mem_req      = 1'b1;
                w_mem_is_fetch = 1'b1;
                if (mem_ack) begin
                    // IR load and PC+1 share the acknowledging cycle.
                    w_ir_en      = 1'b1;
                    w_pc_en      = 1'b1;
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                if (w_class == CLS_HALT) begin
                    // HALT retires as soon as it is recognised.
                    w_retire     = 1'b1;
                    w_next_state = HALT;
                end else begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                case (w_class)
                    CLS_ALU:   w_next_state = WB;
                    CLS_STORE,
                    CLS_LOAD:  w_next_state = MEM;
                    CLS_BEQ: begin
                        w_pc_en      = alu_zero;
                        w_pc_src     = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = FETCH;
                    end
                    CLS_JUMP: begin
                        w_pc_en      = 1'b1;
                        w_pc_src     = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = FETCH;
                    end
                    default: begin
                        w_retire     = 1'b1;
                        w_next_state = FETCH;
                    end
                endcase
            end
            MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_class == CLS_STORE);
                if (mem_ack) begin
                    if (w_class == CLS_STORE) begin
                        w_retire     = 1'b1;
                        w_next_state = FETCH;
                    end else begin
                        w_next_state = WB;
                    end
                end
            end
            WB: begin
                w_reg_write_en = 1'b1;
                w_wb_from_mem  = (w_class == CLS_LOAD);
                w_retire       = 1'b1;
                w_next_state   = FETCH;
            end
            HALT: begin
                w_halted = 1'b1;
                if (resume) begin
                    w_next_state = FETCH;
                end
            end
            default: w_next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end
        end
    end

    // All outputs are gated by rst_n. This forces them to zero while reset is
    // active, so a request that is in flight drops asynchronously.
    assign mem_req      = rst_n & w_mem_req;
    assign mem_we       = rst_n & w_mem_we;
    assign mem_is_fetch = rst_n & w_mem_is_fetch;
    assign ir_en        = rst_n & w_ir_en;
    assign pc_en        = rst_n & w_pc_en;
    assign pc_src       = rst_n & w_pc_src;
    assign reg_write_en = rst_n & w_reg_write_en;
    assign wb_from_mem  = rst_n & w_wb_from_mem;
    assign halted       = rst_n & w_halted;
    assign itype        = rst_n & w_itype;
    assign alu_op       = {ALU_OP_WIDTH{rst_n}} & w_alu_op;
    assign instret      = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control. Each
//               instruction is expanded into the cycles it must take, based
//               on its class and the memory wait times applied. One compare
//               process checks every queued cycle. A second instance with a
//               4-bit counter exercises the counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        resume = 1'b0;

    logic        mem_req, mem_we, mem_is_fetch, ir_en, pc_en, pc_src;
    logic        reg_write_en, wb_from_mem, itype, halted;
    logic [1:0]  alu_op;
    logic [31:0] instret;

    logic        n_mem_req, n_mem_we, n_mem_is_fetch, n_ir_en, n_pc_en, n_pc_src;
    logic        n_reg_write_en, n_wb_from_mem, n_itype, n_halted;
    logic [1:0]  n_alu_op;
    logic [3:0]  n_instret;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .resume(resume),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
        .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src),
        .reg_write_en(reg_write_en), .wb_from_mem(wb_from_mem),
        .itype(itype), .alu_op(alu_op), .halted(halted), .instret(instret)
    );

    multicycle_control #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .resume(resume),
        .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_is_fetch(n_mem_is_fetch),
        .ir_en(n_ir_en), .pc_en(n_pc_en), .pc_src(n_pc_src),
        .reg_write_en(n_reg_write_en), .wb_from_mem(n_wb_from_mem),
        .itype(n_itype), .alu_op(n_alu_op), .halted(n_halted), .instret(n_instret)
    );

    // Expected output values for one clock cycle.
    typedef struct {
        bit          req, we, fetch, ir, pc, src, rwe, wbm, hlt, chk_alu, it;
        bit [1:0]    aop;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] m_instret = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Queue one expected cycle and advance to just after the next rising
    // edge. Retirement is counted once the final cycle has been queued.
    task automatic step(input exp_t e, input bit fin);
        e.cnt = m_instret;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (fin) m_instret = m_instret + 1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("mem_req",      {31'd0, mem_req},      {31'd0, cur.req});
            chk("mem_we",       {31'd0, mem_we},       {31'd0, cur.we});
            chk("mem_is_fetch", {31'd0, mem_is_fetch}, {31'd0, cur.fetch});
            chk("ir_en",        {31'd0, ir_en},        {31'd0, cur.ir});
            chk("pc_en",        {31'd0, pc_en},        {31'd0, cur.pc});
            chk("pc_src",       {31'd0, pc_src},       {31'd0, cur.src});
            chk("reg_write_en", {31'd0, reg_write_en}, {31'd0, cur.rwe});
            chk("wb_from_mem",  {31'd0, wb_from_mem},  {31'd0, cur.wbm});
            chk("halted",       {31'd0, halted},       {31'd0, cur.hlt});
            chk("instret",      instret,               cur.cnt);
            chk("instret_w4",   {28'd0, n_instret},    {28'd0, cur.cnt[3:0]});
            if (cur.chk_alu) begin
                chk("alu_op", {30'd0, alu_op}, {30'd0, cur.aop});
                chk("itype",  {31'd0, itype},  {31'd0, cur.it});
            end
        end
    end

    // Run one whole instruction. fw and mw are the numbers of wait cycles
    // inserted before mem_ack in fetch and in the memory phase.
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input bit zero);
        exp_t r;
        bit is_alu, is_st, is_ld, is_beq, is_jmp, is_halt;
        is_alu  = (op[3] == 1'b0);
        is_st   = (op == 4'b1000);
        is_beq  = (op == 4'b1001);
        is_jmp  = (op == 4'b1010);
        is_ld   = (op == 4'b1011);
        is_halt = (op == 4'b1111);

        // Fetch: the request is held through the wait cycles, then acknowledged.
        for (int i = 0; i < fw; i++) begin
            mem_ack = 1'b0;
            r = blank(); r.req = 1; r.fetch = 1;
            step(r, 0);
        end
        mem_ack = 1'b1;
        r = blank(); r.req = 1; r.fetch = 1; r.ir = 1; r.pc = 1;
        step(r, 0);

        // Decode: a stray ack, and for non-HALT a stray resume, must be ignored.
        instr    = {op, 12'h5A3};
        alu_zero = zero;
        mem_ack  = 1'b1;
        resume   = !is_halt;
        r = blank();
        step(r, is_halt);
        mem_ack = 1'b0;
        resume  = 1'b0;

        if (is_halt) begin
            for (int i = 0; i < 20; i++) begin
                mem_ack = (i % 3 == 0);
                resume  = (i == 19);
                r = blank(); r.hlt = 1;
                step(r, 0);
            end
            mem_ack = 1'b0;
            resume  = 1'b0;
            return;
        end

        // Exec
        r = blank(); r.chk_alu = 1; r.aop = op[1:0]; r.it = (op[3:2] == 2'b01);
        if (is_beq) begin r.pc = zero; r.src = 1; end
        if (is_jmp) begin r.pc = 1;    r.src = 1; end
        step(r, !(is_alu || is_st || is_ld));

        if (is_st || is_ld) begin
            for (int i = 0; i < mw; i++) begin
                r = blank(); r.req = 1; r.we = is_st;
                step(r, 0);
            end
            mem_ack = 1'b1;
            r = blank(); r.req = 1; r.we = is_st;
            step(r, is_st);
            mem_ack = 1'b0;
        end
        if (is_alu || is_ld) begin
            r = blank(); r.rwe = 1; r.wbm = is_ld;
            step(r, 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        resume  = 1'b1;
        #1;
        chk("rst_mem_req",  {31'd0, mem_req},      32'd0);
        chk("rst_fetch",    {31'd0, mem_is_fetch}, 32'd0);
        chk("rst_ir_en",    {31'd0, ir_en},        32'd0);
        chk("rst_pc_en",    {31'd0, pc_en},        32'd0);
        chk("rst_halted",   {31'd0, halted},       32'd0);
        chk("rst_instret",  instret,               32'd0);
        repeat (2) @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        resume    = 1'b0;
        rst_n     = 1'b1;
        m_instret = '0;
    endtask

    initial begin
        exp_t r;
        do_reset();

        // Test 1: ALU op with a zero-wait fetch.
        run_instr(4'b0010, 0, 0, 0);
        chk("t1_instret", instret, 32'd1);

        // Other main-path instructions.
        run_instr(4'b0111, 2, 0, 0);   // I-type ALU after a slow fetch
        run_instr(4'b1000, 1, 0, 0);   // STORE, zero-wait in MEM
        run_instr(4'b1011, 0, 3, 0);   // Test 2: LOAD, ack 3 cycles late
        run_instr(4'b1001, 0, 0, 1);   // Test 3: BEQ taken
        run_instr(4'b1001, 0, 0, 0);   // BEQ not taken
        run_instr(4'b1010, 0, 0, 0);   // JUMP
        run_instr(4'b1100, 0, 0, 0);   // NOP
        chk("t3_instret", instret, 32'd8);

        // Test 4: HALT, then resume.
        run_instr(4'b1111, 0, 0, 0);
        chk("t4_resumed_halted", {31'd0, halted},  32'd0);
        chk("t4_resumed_req",    {31'd0, mem_req}, 32'd1);
        chk("t4_instret",        instret,          32'd9);
        run_instr(4'b0101, 0, 0, 0);

        // Test 5: 16 NOPs from reset wrap the 4-bit counter to zero.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_instr(4'b1100 + 4'(i % 3), i % 2, 0, 0);
        end
        chk("t5_wrap_w4",  {28'd0, n_instret}, 32'd0);
        chk("t5_count_32", instret,            32'd16);

        // Test 6: reset asserted while a STORE waits in MEM.
        mem_ack = 1'b1;
        r = blank(); r.req = 1; r.fetch = 1; r.ir = 1; r.pc = 1;
        step(r, 0);
        instr = {4'b1000, 12'h0F0};
        mem_ack = 1'b0;
        r = blank();
        step(r, 0);
        r = blank(); r.chk_alu = 1; r.aop = 2'b00; r.it = 0;
        step(r, 0);
        r = blank(); r.req = 1; r.we = 1;
        step(r, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_drop", {31'd0, mem_req}, 32'd0);
        chk("t6_we_drop",  {31'd0, mem_we},  32'd0);
        chk("t6_instret",  instret,          32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        m_instret = '0;
        run_instr(4'b0001, 0, 0, 0);
        chk("t6_after_instret", instret, 32'd1);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
